fetch_loader_unit: RTL and testbench

- Next-generation instruction fetch and operand-matrix loader for the SIMD processor. Sits between instruction/data memories and the lane array.
- Keeps a program counter with advance, jump and stall. Tags the returning synchronous-memory instruction as valid.
- Loads an N x N operand matrix from N-wide row beats over a valid/ready handshake. Two modes: A mode broadcasts one row to all rows; B mode fills rows sequentially with an internal row counter.
- Muxes the result word out without tristates.

---
 rtl/fetch_loader_pkg.sv | 22 ++
 rtl/fetch_loader_unit_if.sv | 28 ++
 rtl/fetch_loader_unit_pc_unit.sv | 59 +++++
 rtl/fetch_loader_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_loader_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_loader_pkg.sv
// Shared definitions for the fetch / operand-matrix loader.
// Contents:
//   load_state_e   - matrix loader FSM state encoding
//   MODE_A/MODE_B  - load_mode encodings (broadcast / row-sequential)
//   is_loading()   - true while the loader accepts row beats
package fetch_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } load_state_e;

    localparam logic MODE_A = 1'b1;
    localparam logic MODE_B = 1'b0;

    function automatic logic is_loading(input logic [1:0] st);
        return (st == LOAD_A) || (st == LOAD_B);
    endfunction

endpackage

// File: rtl/fetch_loader_unit_if.sv
// Row-beat handshake bus feeding the operand-matrix loader.
// Signals:
//   row_in    - one N-lane row, lane 0 in the LSBs
//   row_valid - row_in carries a beat
//   row_ready - loader accepts a beat this cycle
// Modports: master drives rows, slave (the loader) returns ready.
interface fetch_loader_unit_if #(
    parameter int N  = 16,
    parameter int DW = 32
) ();

    logic [N*DW-1:0] row_in;
    logic            row_valid;
    logic            row_ready;

    modport master (
        output row_in,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_in,
        input  row_valid,
        output row_ready
    );

endinterface

// File: rtl/fetch_loader_unit_pc_unit.sv
// Program counter for the instruction fetch path.
// Ports:
//   CLK, RSTN     - clock, synchronous active-low reset
//   pc_advance_i  - step PC by one (wraps at IMEM_DEPTH)
//   jump_en_i     - load PC from jump_addr_i (highest priority)
//   jump_addr_i   - jump target
//   stall_i       - hold PC (beats advance, loses to jump)
//   pc_out_o      - registered instruction memory address
//   instr_valid_o - the synchronous memory output matches pc_out_o
module pc_unit
    import fetch_loader_pkg::*;
#(
    parameter int              IMEM_DEPTH = 256,
    parameter int              AW         = $clog2(IMEM_DEPTH),
    parameter logic [AW-1:0]   START_ADDR = '0
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          pc_advance_i,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          stall_i,
    output logic [AW-1:0] pc_out_o,
    output logic          instr_valid_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic          valid_q;
    logic          valid_d;

    always_comb begin
        pc_d = pc_q;
        if (jump_en_i) begin
            pc_d = jump_addr_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pc_advance_i) begin
            // IMEM_DEPTH is a power of two, so natural overflow is the wrap
            pc_d = pc_q + AW'(1);
        end
        // Memory needs one cycle to catch up with any new address
        valid_d = (pc_d == pc_q);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            pc_q    <= START_ADDR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out_o      = pc_q;
    assign instr_valid_o = valid_q;

endmodule

// File: rtl/fetch_loader_unit.sv
// Instruction fetch and N x N operand-matrix loader for the SIMD lane array.
// Ports:
//   CLK, RSTN          - clock, synchronous active-low reset
//   pc_advance_i, jump_en_i, jump_addr_i, stall_i - PC control
//   pc_out_o           - instruction memory address
//   instr_data_i       - instruction memory read data (1-cycle sync read)
//   instr_out_o        - instruction word passed through
//   instr_valid_o      - instr_out_o belongs to pc_out_o
//   load_start_i       - begin a matrix load (IDLE only)
//   load_mode_i        - 1 broadcast (A), 0 row-sequential (B)
//   row_bus            - row beat handshake (slave side)
//   load_busy_o        - load in progress
//   load_done_o        - one-cycle completion pulse
//   row_idx_o          - next row written by a B load
//   mat_out_o          - matrix, row r at [r*N*DW +: N*DW]
//   dout_sel_i, dataout_i, result_o - result gating mux
//
// Loader FSM:
//   state  | meaning
//   IDLE   | waiting for load_start
//   LOAD_A | accept one row, broadcast it to every matrix row
//   LOAD_B | accept N rows, write them in order at row_idx
//   DONE   | pulse load_done, return to IDLE
module fetch_loader_unit
    import fetch_loader_pkg::*;
#(
    parameter int  N          = 16,
    parameter int  DW         = 32,
    parameter int  IMEM_DEPTH = 256,
    parameter int  START_ADDR = 0,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int RW         = $clog2(N)
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                pc_advance_i,
    input  logic                jump_en_i,
    input  logic [AW-1:0]       jump_addr_i,
    input  logic                stall_i,
    output logic [AW-1:0]       pc_out_o,
    input  logic [31:0]         instr_data_i,
    output logic [31:0]         instr_out_o,
    output logic                instr_valid_o,
    input  logic                load_start_i,
    input  logic                load_mode_i,
    fetch_loader_unit_if.slave  row_bus,
    output logic                load_busy_o,
    output logic                load_done_o,
    output logic [RW-1:0]       row_idx_o,
    output logic [N*N*DW-1:0]   mat_out_o,
    input  logic                dout_sel_i,
    input  logic [DW-1:0]       dataout_i,
    output logic [DW-1:0]       result_o
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LOAD_A = LOAD_A;
    localparam logic [1:0] S_LOAD_B = LOAD_B;
    localparam logic [1:0] S_DONE   = DONE;

    typedef logic [N*DW-1:0] row_t;
    typedef row_t [N-1:0]    mat_t;

    pc_unit #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (AW),
        .START_ADDR (AW'(START_ADDR))
    ) u_pc (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .pc_advance_i  (pc_advance_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .stall_i       (stall_i),
        .pc_out_o      (pc_out_o),
        .instr_valid_o (instr_valid_o)
    );

    assign instr_out_o = instr_data_i;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [RW-1:0] row_idx_q;
    logic [RW-1:0] row_idx_d;
    mat_t          mat_q;
    mat_t          mat_d;
    logic          row_ready;
    logic          row_hs;

    // Ready decodes the state register only, so it never loops back
    // through row_valid.
    assign row_ready = is_loading(state_q);
    assign row_hs    = row_bus.row_valid & row_ready;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        mat_d     = mat_q;
        case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    state_d = (load_mode_i == MODE_A) ? S_LOAD_A : S_LOAD_B;
                end
            end
            S_LOAD_A: begin
                if (row_hs) begin
                    for (int r = 0; r < N; r++) begin
                        mat_d[r] = row_bus.row_in;
                    end
                    state_d = S_DONE;
                end
            end
            S_LOAD_B: begin
                if (row_hs) begin
                    mat_d[row_idx_q] = row_bus.row_in;
                    // N is a power of two: the last row wraps the index to 0
                    row_idx_d = row_idx_q + RW'(1);
                    if (row_idx_q == RW'(N - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            row_idx_q <= '0;
            mat_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            mat_q     <= mat_d;
        end
    end

    assign row_bus.row_ready = row_ready;
    assign load_busy_o       = row_ready;
    assign load_done_o       = (state_q == S_DONE);
    assign row_idx_o         = row_idx_q;
    assign mat_out_o         = mat_q;

    assign result_o = dout_sel_i ? dataout_i : '0;

endmodule

// File: tb/tb_fetch_loader_unit.sv
module tb_fetch_loader_unit;

    localparam int N          = 16;
    localparam int DW         = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int AW         = 8;
    localparam int RW         = 4;

    logic                CLK = 1'b0;
    logic                RSTN = 1'b0;
    logic                pc_advance = 1'b0;
    logic                jump_en = 1'b0;
    logic [AW-1:0]       jump_addr = '0;
    logic                stall = 1'b0;
    logic [AW-1:0]       pc_out;
    logic [31:0]         instr_data;
    logic [31:0]         instr_out;
    logic                instr_valid;
    logic                load_start = 1'b0;
    logic                load_mode = 1'b0;
    logic                load_busy;
    logic                load_done;
    logic [RW-1:0]       row_idx;
    logic [N*N*DW-1:0]   mat_out;
    logic                dout_sel = 1'b0;
    logic [DW-1:0]       dataout = '0;
    logic [DW-1:0]       result;

    fetch_loader_unit_if #(.N(N), .DW(DW)) row_bus ();

    fetch_loader_unit #(
        .N          (N),
        .DW         (DW),
        .IMEM_DEPTH (IMEM_DEPTH),
        .START_ADDR (0)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .pc_advance_i  (pc_advance),
        .jump_en_i     (jump_en),
        .jump_addr_i   (jump_addr),
        .stall_i       (stall),
        .pc_out_o      (pc_out),
        .instr_data_i  (instr_data),
        .instr_out_o   (instr_out),
        .instr_valid_o (instr_valid),
        .load_start_i  (load_start),
        .load_mode_i   (load_mode),
        .row_bus       (row_bus),
        .load_busy_o   (load_busy),
        .load_done_o   (load_done),
        .row_idx_o     (row_idx),
        .mat_out_o     (mat_out),
        .dout_sel_i    (dout_sel),
        .dataout_i     (dataout),
        .result_o      (result)
    );

    always #5 CLK = ~CLK;

    logic [31:0] imem [IMEM_DEPTH];
    always @(posedge CLK) instr_data <= imem[pc_out];

    typedef struct {
        string        tag;
        logic [511:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [AW-1:0] exp_pc = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [511:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [511:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underflow: observed %0h expected nothing", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N*DW-1:0] fill(input logic [31:0] v);
        logic [N*DW-1:0] row;
        for (int l = 0; l < N; l++) row[l*DW +: DW] = v;
        return row;
    endfunction

    function automatic logic [N*DW-1:0] ramp();
        logic [N*DW-1:0] row;
        for (int l = 0; l < N; l++) row[l*DW +: DW] = 32'(l);
        return row;
    endfunction

    function automatic logic [N*DW-1:0] mrow(input int r);
        return mat_out[r*N*DW +: N*DW];
    endfunction

    task automatic drive_pc(input logic adv, input logic jmp, input logic [AW-1:0] addr,
                            input logic stl);
        logic [AW-1:0] nxt;
        pc_advance = adv;
        jump_en    = jmp;
        jump_addr  = addr;
        stall      = stl;
        if (jmp)      nxt = addr;
        else if (stl) nxt = exp_pc;
        else if (adv) nxt = exp_pc + 8'd1;
        else          nxt = exp_pc;
        sb_push("pc_out", 512'(nxt));
        sb_push("instr_valid", 512'(nxt == exp_pc));
        tick();
        sb_check(512'(pc_out));
        sb_check(512'(instr_valid));
        exp_pc     = nxt;
        pc_advance = 1'b0;
        jump_en    = 1'b0;
        stall      = 1'b0;
    endtask

    initial begin
        int exp_idx;
        int r;
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'hC0DE0000 + 32'(i);
        row_bus.row_in    = '0;
        row_bus.row_valid = 1'b0;

        // reset and release
        tick();
        tick();
        RSTN = 1'b1;
        chk("rst_pc", 512'(pc_out), 512'(0));
        chk("rst_valid", 512'(instr_valid), 512'(0));
        chk("rst_ready", 512'(row_bus.row_ready), 512'(0));
        chk("rst_busy", 512'(load_busy), 512'(0));
        chk("rst_done", 512'(load_done), 512'(0));
        chk("rst_row_idx", 512'(row_idx), 512'(0));
        chk("rst_mat_zero", 512'(mat_out === '0), 512'(1));
        tick();
        chk("post_rst_valid", 512'(instr_valid), 512'(1));
        chk("post_rst_instr", 512'(instr_out), 512'(imem[0]));

        // PC: advance, stall, jump priority, wrap
        drive_pc(1'b1, 1'b0, 8'h00, 1'b0);
        drive_pc(1'b1, 1'b0, 8'h00, 1'b0);
        drive_pc(1'b1, 1'b0, 8'h00, 1'b0);
        drive_pc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("instr_at_3", 512'(instr_out), 512'(imem[3]));
        drive_pc(1'b0, 1'b1, 8'h80, 1'b1);
        drive_pc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("instr_at_80", 512'(instr_out), 512'(imem[8'h80]));
        drive_pc(1'b0, 1'b1, 8'hFF, 1'b0);
        drive_pc(1'b1, 1'b0, 8'h00, 1'b0);
        drive_pc(1'b1, 1'b1, 8'h10, 1'b0);
        drive_pc(1'b0, 1'b0, 8'h00, 1'b0);

        // A (broadcast) load
        load_mode  = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("a_ready", 512'(row_bus.row_ready), 512'(1));
        chk("a_busy", 512'(load_busy), 512'(1));
        row_bus.row_in    = ramp();
        row_bus.row_valid = 1'b1;
        for (int i = 0; i < N; i++) sb_push("a_row", 512'(ramp()));
        tick();
        row_bus.row_valid = 1'b0;
        chk("a_done", 512'(load_done), 512'(1));
        chk("a_done_busy", 512'(load_busy), 512'(0));
        chk("a_row_idx", 512'(row_idx), 512'(0));
        for (int i = 0; i < N; i++) sb_check(512'(mrow(i)));
        tick();
        chk("a_done_clear", 512'(load_done), 512'(0));
        chk("a_idle_ready", 512'(row_bus.row_ready), 512'(0));

        // B (row-sequential) load with gapped valid and an ignored load_start
        load_mode  = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("b_ready", 512'(row_bus.row_ready), 512'(1));
        exp_idx = 0;
        for (int k = 0; k <= 30; k++) begin
            if (k % 2 == 0) begin
                r = k / 2;
                row_bus.row_in    = fill(32'(r + 100));
                row_bus.row_valid = 1'b1;
                sb_push("b_row", 512'(fill(32'(r + 100))));
                exp_idx = (r + 1) % N;
            end else begin
                row_bus.row_valid = 1'b0;
            end
            if (k == 5) begin
                load_start = 1'b1;
                load_mode  = 1'b1;
            end
            tick();
            load_start        = 1'b0;
            row_bus.row_valid = 1'b0;
            chk("b_row_idx", 512'(row_idx), 512'(exp_idx));
            if (k < 30) chk("b_busy", 512'(load_busy), 512'(1));
            if (k == 0) chk("b_row1_hold", 512'(mrow(1)), 512'(ramp()));
        end
        load_mode = 1'b0;
        chk("b_done", 512'(load_done), 512'(1));
        chk("b_done_idx", 512'(row_idx), 512'(0));
        for (int i = 0; i < N; i++) sb_check(512'(mrow(i)));
        tick();
        chk("b_done_clear", 512'(load_done), 512'(0));

        // reset in the middle of a B load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        row_bus.row_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            row_bus.row_in = fill(32'h700 + 32'(i));
            tick();
        end
        row_bus.row_valid = 1'b0;
        chk("mid_row_idx", 512'(row_idx), 512'(5));
        chk("mid_row2", 512'(mrow(2)), 512'(fill(32'h702)));
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        chk("mrst_mat_zero", 512'(mat_out === '0), 512'(1));
        chk("mrst_ready", 512'(row_bus.row_ready), 512'(0));
        chk("mrst_busy", 512'(load_busy), 512'(0));
        chk("mrst_row_idx", 512'(row_idx), 512'(0));
        chk("mrst_pc", 512'(pc_out), 512'(0));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        row_bus.row_in    = fill(32'h55);
        row_bus.row_valid = 1'b1;
        sb_push("restart_row0", 512'(fill(32'h55)));
        tick();
        row_bus.row_valid = 1'b0;
        sb_check(512'(mrow(0)));
        chk("restart_row_idx", 512'(row_idx), 512'(1));
        chk("restart_row1_zero", 512'(mrow(1)), 512'(0));

        // result mux
        dout_sel = 1'b1;
        dataout  = 32'hDEADBEEF;
        #1;
        chk("result_sel", 512'(result), 512'(32'hDEADBEEF));
        dataout = 32'h12345678;
        #1;
        chk("result_sel2", 512'(result), 512'(32'h12345678));
        dout_sel = 1'b0;
        #1;
        chk("result_zero", 512'(result), 512'(0));

        chk("sb_empty", 512'(sb_q.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
